dnd_patch_sequencer: RTL and testbench

DND_PATCH_SEQUENCER -- requirements
Module: dnd_patch_sequencer

---
 rtl/dnd_patch_sequencer_if.sv | 62 ++++++
 rtl/dnd_patch_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_dnd_patch_sequencer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dnd_patch_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dnd_patch_sequencer_if                                                    |
// | Event, patch-memory and activation-stream signals of the patch sequencer. |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
interface dnd_patch_sequencer_if #(
  parameter int DVS_WIDTH       = 346,
  parameter int DVS_HEIGHT      = 260,
  parameter int CAVIAR_X_Y_BITS = 9,
  parameter int TIMESTAMP_BITS  = 16,
  parameter int POLARITY_BITS   = 2,
  parameter int WORD_SIZE       = 18,
  parameter int W_X             = 4,
  parameter int W_ADDR          = $clog2(DVS_WIDTH * DVS_HEIGHT)
);
  logic [CAVIAR_X_Y_BITS-1:0]           ev_x;
  logic [CAVIAR_X_Y_BITS-1:0]           ev_y;
  logic [POLARITY_BITS-1:0]             ev_pol;
  logic [TIMESTAMP_BITS-1:0]            ev_ts;
  logic                                 ev_vld;
  logic                                 ev_rdy;
  logic                                 mem_rd_en;
  logic [W_ADDR-1:0]                    mem_rd_addr1;
  logic [W_ADDR-1:0]                    mem_rd_addr2;
  logic                                 mem_rd_vld1;
  logic                                 mem_rd_vld2;
  logic [WORD_SIZE-1:0]                 mem_rd_data1;
  logic [WORD_SIZE-1:0]                 mem_rd_data2;
  logic                                 mem_wr_en;
  logic [W_ADDR-1:0]                    mem_wr_addr;
  logic [WORD_SIZE-1:0]                 mem_wr_data;
  logic [1:0][W_X-1:0]                  act_mag;
  logic [1:0][POLARITY_BITS-1:0]        act_pol;
  logic                                 act_vld;
  logic                                 act_rdy;
  logic                                 act_last;
  logic                                 busy;

  modport master (
    input  ev_x, ev_y, ev_pol, ev_ts, ev_vld,
    output ev_rdy,
    output mem_rd_en, mem_rd_addr1, mem_rd_addr2,
    input  mem_rd_vld1, mem_rd_vld2, mem_rd_data1, mem_rd_data2,
    output mem_wr_en, mem_wr_addr, mem_wr_data,
    output act_mag, act_pol, act_vld, act_last,
    input  act_rdy,
    output busy
  );

  modport slave (
    output ev_x, ev_y, ev_pol, ev_ts, ev_vld,
    input  ev_rdy,
    input  mem_rd_en, mem_rd_addr1, mem_rd_addr2,
    output mem_rd_vld1, mem_rd_vld2, mem_rd_data1, mem_rd_data2,
    input  mem_wr_en, mem_wr_addr, mem_wr_data,
    input  act_mag, act_pol, act_vld, act_last,
    output act_rdy,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/dnd_patch_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dnd_patch_sequencer                                                       |
// | Reads a (2R+1)^2 timestamp patch around each DVS event two pixels per     |
// | beat, streams age-based activations, then writes the event back.          |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module dnd_patch_sequencer #(
  parameter int DVS_WIDTH       = 346,
  parameter int DVS_HEIGHT      = 260,
  parameter int CAVIAR_X_Y_BITS = 9,
  parameter int TIMESTAMP_BITS  = 16,
  parameter int POLARITY_BITS   = 2,
  parameter int WORD_SIZE       = 18,
  parameter int PATCH_R         = 3,
  parameter int W_X             = 4,
  parameter int AGE_SHIFT       = 3
) (
  input  wire logic                clk,
  input  wire logic                rst,
  dnd_patch_sequencer_if.master    bus
);
  localparam int W_ADDR  = $clog2(DVS_WIDTH * DVS_HEIGHT);
  localparam int c_D     = 2 * PATCH_R + 1;
  localparam int c_NPIX  = c_D * c_D;
  localparam int c_NBEAT = (c_NPIX + 1) / 2;
  localparam int c_KW    = $clog2(c_NBEAT + 1);
  localparam int c_CW    = $clog2(c_D + 1);
  localparam int c_XW    = CAVIAR_X_Y_BITS + 2;
  localparam logic [W_X-1:0] c_MAG_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_OUT   = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t r_state, w_next;

  logic                         r_alive;
  logic [CAVIAR_X_Y_BITS-1:0]   r_x, r_y;
  logic [POLARITY_BITS-1:0]     r_pol;
  logic [TIMESTAMP_BITS-1:0]    r_ts;
  logic [c_KW-1:0]              r_k;
  logic [c_CW-1:0]              r_c0, r_r0;
  logic [WORD_SIZE-1:0]         r_d1, r_d2;
  logic                         r_got1, r_got2;
  logic [1:0][W_X-1:0]          r_act_mag;
  logic [1:0][POLARITY_BITS-1:0] r_act_pol;
  logic                         r_act_last;

  logic                         w_ev_rdy, w_accept, w_in_range, w_both;
  logic [c_CW-1:0]              w_col [2];
  logic [c_CW-1:0]              w_row [2];
  logic [WORD_SIZE-1:0]         w_word [2];
  logic [W_ADDR-1:0]            w_lane_addr [2];
  logic [W_X-1:0]               w_lane_mag [2];
  logic [POLARITY_BITS-1:0]     w_lane_pol [2];

  assign w_ev_rdy   = (r_state == S_IDLE) && r_alive;
  assign w_accept   = bus.ev_vld && w_ev_rdy;
  assign w_in_range = (int'(bus.ev_x) < DVS_WIDTH) && (int'(bus.ev_y) < DVS_HEIGHT);
  assign w_both     = (r_got1 || bus.mem_rd_vld1) && (r_got2 || bus.mem_rd_vld2);
  assign w_word[0]  = bus.mem_rd_vld1 ? bus.mem_rd_data1 : r_d1;
  assign w_word[1]  = bus.mem_rd_vld2 ? bus.mem_rd_data2 : r_d2;

  // Lane 0 walks (r_r0, r_c0); lane 1 is the next pixel in row-major order.
  always_comb begin
    w_col[0] = r_c0;
    w_row[0] = r_r0;
    w_col[1] = r_c0 + c_CW'(1);
    w_row[1] = r_r0;
    if (int'(r_c0) == c_D - 1) begin
      w_col[1] = '0;
      w_row[1] = r_r0 + c_CW'(1);
    end
  end

  for (genvar l = 0; l < 2; l++) begin : g_lane
    logic [c_XW-1:0]            w_tx, w_ty;
    logic                       w_pad, w_oob;
    logic [TIMESTAMP_BITS-1:0]  w_age, w_sh;
    logic [POLARITY_BITS-1:0]   w_spol;

    // Coordinates are offset by +R so the patch origin never goes negative.
    assign w_tx  = {2'b00, r_x} + c_XW'(w_col[l]);
    assign w_ty  = {2'b00, r_y} + c_XW'(w_row[l]);
    assign w_pad = int'(w_row[l]) >= c_D;
    assign w_oob = !w_pad && ((int'(w_tx) < PATCH_R) || (int'(w_tx) - PATCH_R >= DVS_WIDTH) ||
                              (int'(w_ty) < PATCH_R) || (int'(w_ty) - PATCH_R >= DVS_HEIGHT));
    assign w_lane_addr[l] = (w_pad || w_oob) ? '0 :
        W_ADDR'(int'(w_tx) - PATCH_R + DVS_WIDTH * (int'(w_ty) - PATCH_R));

    assign w_spol = w_word[l][WORD_SIZE-1 -: POLARITY_BITS];
    assign w_age  = r_ts - w_word[l][TIMESTAMP_BITS-1:0];
    assign w_sh   = w_age >> AGE_SHIFT;

    always_comb begin
      w_lane_mag[l] = c_MAG_MAX;
      w_lane_pol[l] = '0;
      if (w_pad) begin
        w_lane_mag[l] = '0;
      end else if (!w_oob && (w_spol != '0)) begin
        w_lane_pol[l] = w_spol;
        if (w_sh <= TIMESTAMP_BITS'(c_MAG_MAX))
          w_lane_mag[l] = w_sh[W_X-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next            = r_state;
    bus.ev_rdy        = w_ev_rdy;
    bus.mem_rd_en     = 1'b0;
    bus.mem_rd_addr1  = '0;
    bus.mem_rd_addr2  = '0;
    bus.mem_wr_en     = 1'b0;
    bus.mem_wr_addr   = '0;
    bus.mem_wr_data   = '0;
    bus.act_vld       = 1'b0;
    bus.busy          = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: if (w_accept && w_in_range) w_next = S_READ;
      S_READ: begin
        bus.mem_rd_en    = 1'b1;
        bus.mem_rd_addr1 = w_lane_addr[0];
        bus.mem_rd_addr2 = w_lane_addr[1];
        w_next           = S_WAIT;
      end
      S_WAIT: if (w_both) w_next = S_OUT;
      S_OUT: begin
        bus.act_vld = 1'b1;
        if (bus.act_rdy) w_next = r_act_last ? S_WRITE : S_READ;
      end
      S_WRITE: begin
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_addr = W_ADDR'(int'(r_x) + DVS_WIDTH * int'(r_y));
        bus.mem_wr_data = {r_pol, r_ts};
        w_next          = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.act_mag  = r_act_mag;
  assign bus.act_pol  = r_act_pol;
  assign bus.act_last = r_act_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alive    <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_pol      <= '0;
      r_ts       <= '0;
      r_k        <= '0;
      r_c0       <= '0;
      r_r0       <= '0;
      r_d1       <= '0;
      r_d2       <= '0;
      r_got1     <= 1'b0;
      r_got2     <= 1'b0;
      r_act_mag  <= '0;
      r_act_pol  <= '0;
      r_act_last <= 1'b0;
    end else begin
      r_alive <= 1'b1;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_x   <= bus.ev_x;
          r_y   <= bus.ev_y;
          r_pol <= bus.ev_pol;
          r_ts  <= bus.ev_ts;
          r_k   <= '0;
          r_c0  <= '0;
          r_r0  <= '0;
        end
        S_READ: begin
          r_got1 <= 1'b0;
          r_got2 <= 1'b0;
        end
        S_WAIT: begin
          if (bus.mem_rd_vld1) begin
            r_d1   <= bus.mem_rd_data1;
            r_got1 <= 1'b1;
          end
          if (bus.mem_rd_vld2) begin
            r_d2   <= bus.mem_rd_data2;
            r_got2 <= 1'b1;
          end
          if (w_both) begin
            r_act_mag  <= {w_lane_mag[1], w_lane_mag[0]};
            r_act_pol  <= {w_lane_pol[1], w_lane_pol[0]};
            r_act_last <= (int'(r_k) == c_NBEAT - 1);
          end
        end
        S_OUT: if (bus.act_rdy && !r_act_last) begin
          r_k <= r_k + c_KW'(1);
          if (int'(r_c0) + 2 >= c_D) begin
            r_c0 <= c_CW'(int'(r_c0) + 2 - c_D);
            r_r0 <= r_r0 + c_CW'(1);
          end else begin
            r_c0 <= r_c0 + c_CW'(2);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_dnd_patch_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dnd_patch_sequencer                                                    |
// | Directed events against a behavioural patch memory with a beat scoreboard.|
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_dnd_patch_sequencer;
  typedef struct packed {
    logic [3:0] m0;
    logic [1:0] p0;
    logic [3:0] m1;
    logic [1:0] p1;
    logic       last;
  } beat_t;

  logic clk;
  logic rst;

  dnd_patch_sequencer_if bus ();

  dnd_patch_sequencer u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [17:0] mem [0:131071];
  beat_t       exp_q[$];
  logic [34:0] exp_wq[$];
  beat_t       cap [0:31];
  int          n_vec = 0;
  int          n_err = 0;
  int          beats_done = 0;
  int          rd_count = 0;
  int          wr_count = 0;
  int          hold_beat = -1;
  int          hold_len = 0;
  int          hold_cnt = 0;
  logic [34:0] last_wr;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected lane value straight from the patch definition.
  function automatic logic [5:0] ref_lane(int p, int x, int y, logic [15:0] ts);
    int dx, dy, px, py, m;
    logic [17:0] w;
    logic [15:0] age;
    if (p >= 49) return 6'b0;
    dy = p / 7 - 3;
    dx = p % 7 - 3;
    px = x + dx;
    py = y + dy;
    if (px < 0 || px >= 346 || py < 0 || py >= 260) return {4'd15, 2'b00};
    w = mem[px + 346 * py];
    if (w[17:16] == 2'b00) return {4'd15, 2'b00};
    age = ts - w[15:0];
    m = int'(age) >> 3;
    if (m > 15) m = 15;
    return {4'(m), w[17:16]};
  endfunction

  task automatic issue_event(input int x, input int y, input logic [1:0] pol, input logic [15:0] ts);
    beat_t b;
    logic [5:0] l0, l1;
    int n;
    beats_done = 0;
    if (x < 346 && y < 260) begin
      for (int k = 0; k < 25; k++) begin
        l0 = ref_lane(2 * k, x, y, ts);
        l1 = ref_lane(2 * k + 1, x, y, ts);
        b = '{m0: l0[5:2], p0: l0[1:0], m1: l1[5:2], p1: l1[1:0], last: (k == 24)};
        exp_q.push_back(b);
      end
      exp_wq.push_back({17'(x + 346 * y), pol, ts});
    end
    @(posedge clk); #1;
    bus.ev_x = 9'(x); bus.ev_y = 9'(y); bus.ev_pol = pol; bus.ev_ts = ts; bus.ev_vld = 1'b1;
    n = 0;
    while (!bus.ev_rdy && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 1000) chk("ev_rdy_timeout", 0, 1);
    @(posedge clk); #1;
    bus.ev_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < 5000);
    if (n >= 5000) chk("idle_timeout", 0, 1);
  endtask

  task automatic run_event(input int x, input int y, input logic [1:0] pol, input logic [15:0] ts);
    issue_event(x, y, pol, ts);
    wait_idle();
    chk("beats_outstanding", exp_q.size(), 0);
    chk("writes_outstanding", exp_wq.size(), 0);
  endtask

  // Memory responder: independent random latency per port.
  initial begin
    logic [16:0] a1, a2;
    int l1, l2;
    bus.mem_rd_vld1 = 1'b0; bus.mem_rd_vld2 = 1'b0;
    bus.mem_rd_data1 = '0;  bus.mem_rd_data2 = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_rd_en && !rst) begin
        a1 = bus.mem_rd_addr1; a2 = bus.mem_rd_addr2;
        l1 = $urandom_range(1, 4); l2 = $urandom_range(1, 4);
        fork
          begin
            repeat (l1) @(negedge clk);
            bus.mem_rd_data1 = mem[a1]; bus.mem_rd_vld1 = 1'b1;
            @(negedge clk); bus.mem_rd_vld1 = 1'b0;
          end
          begin
            repeat (l2) @(negedge clk);
            bus.mem_rd_data2 = mem[a2]; bus.mem_rd_vld2 = 1'b1;
            @(negedge clk); bus.mem_rd_vld2 = 1'b0;
          end
        join
      end
    end
  end

  // act_rdy driver with an optional stall on one beat.
  initial begin
    bus.act_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (!rst && bus.act_vld && beats_done == hold_beat && hold_cnt < hold_len) begin
        bus.act_rdy = 1'b0;
        hold_cnt++;
      end else begin
        bus.act_rdy = 1'b1;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    beat_t obs, prev, e;
    logic prev_stall;
    logic [34:0] w;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        obs = '{m0: bus.act_mag[0], p0: bus.act_pol[0], m1: bus.act_mag[1],
                p1: bus.act_pol[1], last: bus.act_last};
        if (bus.mem_rd_en) rd_count++;
        if (bus.mem_rd_en || bus.mem_wr_en) chk("rd_wr_overlap", bus.mem_rd_en & bus.mem_wr_en, 0);
        if (bus.mem_wr_en) begin
          wr_count++;
          w = {bus.mem_wr_addr, bus.mem_wr_data};
          last_wr = w;
          if (exp_wq.size() == 0) chk("unexpected_write", w, 0);
          else chk("write_back", w, exp_wq.pop_front());
          mem[bus.mem_wr_addr] = bus.mem_wr_data;
        end
        if (prev_stall) chk("stall_stable", {bus.act_vld, obs}, {1'b1, prev});
        if (bus.act_vld && bus.act_rdy) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", obs, 0);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("beat%0d", beats_done), obs, e);
          end
          if (beats_done < 32) cap[beats_done] = obs;
          beats_done++;
        end
        prev_stall = bus.act_vld && !bus.act_rdy;
        prev = obs;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, wr0, n;
    for (int i = 0; i < 131072; i++) mem[i] = '0;
    rst = 1'b1;
    bus.ev_vld = 1'b0; bus.ev_x = '0; bus.ev_y = '0; bus.ev_pol = '0; bus.ev_ts = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_act_vld", bus.act_vld, 0);
    chk("rst_rd_en", bus.mem_rd_en, 0);
    chk("rst_wr_en", bus.mem_wr_en, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ev_rdy", bus.ev_rdy, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ev_rdy_after_rst", bus.ev_rdy, 1);

    // Empty memory
    run_event(100, 100, 2'b01, 16'd500);
    chk("empty_b0", cap[0], {4'd15, 2'b00, 4'd15, 2'b00, 1'b0});
    chk("empty_b24", cap[24], {4'd15, 2'b00, 4'd0, 2'b00, 1'b1});
    chk("empty_wr", last_wr, {17'd34700, 2'b01, 16'd500});

    // Neighbour at (101,100) stored 20 ticks earlier
    mem[34701] = {2'b01, 16'd480};
    run_event(100, 100, 2'b01, 16'd500);
    chk("nbr_b12", cap[12], {4'd0, 2'b01, 4'd2, 2'b01, 1'b0});

    // Timestamp wrap-around
    mem[34701] = {2'b10, 16'd65530};
    run_event(100, 100, 2'b10, 16'd10);
    chk("wrap_b12_l1", {cap[12].m1, cap[12].p1}, {4'd2, 2'b10});

    // Saturation at (99,100)
    mem[34699] = {2'b01, 16'd0};
    run_event(100, 100, 2'b01, 16'd400);
    chk("sat_b11_l1", {cap[11].m1, cap[11].p1}, {4'd15, 2'b01});

    // Corner event: beat 0 off-sensor although address 0 holds data
    mem[0] = {2'b01, 16'd100};
    mem[1] = {2'b01, 16'd100};
    run_event(0, 0, 2'b01, 16'd100);
    chk("corner_b0", cap[0], {4'd15, 2'b00, 4'd15, 2'b00, 1'b0});
    chk("corner_b12_l0", {cap[12].m0, cap[12].p0}, {4'd0, 2'b01});

    // Out-of-range event is dropped
    rd0 = rd_count; wr0 = wr_count;
    issue_event(346, 5, 2'b01, 16'd700);
    repeat (10) @(negedge clk);
    chk("drop_no_reads", rd_count, rd0);
    chk("drop_no_write", wr_count, wr0);
    chk("drop_busy", bus.busy, 0);
    chk("drop_ev_rdy", bus.ev_rdy, 1);

    // Back-pressure on beat 3
    hold_beat = 3; hold_len = 5; hold_cnt = 0;
    run_event(200, 50, 2'b01, 16'd1000);
    chk("stall_cycles", hold_cnt, 5);

    // Reset while beat 10 is stalled
    hold_beat = 10; hold_len = 1000000; hold_cnt = 0;
    issue_event(150, 60, 2'b10, 16'd2000);
    n = 0;
    while (hold_cnt < 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_beat10", hold_cnt >= 3, 1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrst_act_vld", bus.act_vld, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_rd_en", bus.mem_rd_en, 0);
    exp_q.delete();
    exp_wq.delete();
    hold_beat = -1;
    wr0 = wr_count;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_no_write", wr_count, wr0);
    chk("midrst_idle", bus.busy, 0);
    chk("midrst_ev_rdy", bus.ev_rdy, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
